// File: rtl/regbank_wr_arbiter.sv
// regbank_wr_arbiter: shares the single register-bank write port between NREQ
// writeback sources (req0 = ALU, req1 = memory load, req2 = input port).
// One source is granted per cycle, its write is registered toward the bank, and
// busy_mask flags every register with a write pending or in the output stage.
// Build option: define REGWR_ARB_RR_EN for round-robin arbitration; leave it
// undefined for fixed priority (req0 highest).
`timescale 1ns/1ps

module regbank_wr_arbiter #(
  parameter int DATA_W = 8,
  parameter int RD_W   = 2,
  parameter int NREQ   = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*RD_W-1:0]   req_rd,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   hold,
  output logic                   WR,
  output logic [RD_W-1:0]        rd,
  output logic [DATA_W-1:0]      data,
  output logic [(1<<RD_W)-1:0]   busy_mask
);

  localparam int NREG  = 1 << RD_W;
  localparam int IDX_W = $clog2(NREQ);

  // Arbitration result (combinational, stage p0)
  logic              found_p0;
  logic              take_p0;
  logic [IDX_W-1:0]  win_p0;
  logic [NREQ-1:0]   grant_p0;
  logic [RD_W-1:0]   sel_rd_p0;
  logic [DATA_W-1:0] sel_data_p0;

  // Registered write toward the bank (stage p1)
  logic              vld_p1;
  logic [RD_W-1:0]   rd_p1;
  logic [DATA_W-1:0] data_p1;

`ifdef REGWR_ARB_RR_EN
  localparam logic [IDX_W:0] NREQ_L = (IDX_W+1)'(NREQ);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_next;

  // Candidate index for scan position k, wrapped modulo NREQ
  function automatic logic [IDX_W-1:0] scan_idx(input logic [IDX_W-1:0] ptr,
                                                input int unsigned    k);
    logic [IDX_W:0] sum;
    sum = {1'b0, ptr} + (IDX_W+1)'(k);
    if (sum >= NREQ_L) sum = sum - NREQ_L;
    return sum[IDX_W-1:0];
  endfunction
`endif

  // ---- stage p0: pick the first valid source from the scan start ----
  // Scan requesters in priority order and remember the first valid one
  always_comb begin
    logic [IDX_W-1:0] cand;
    found_p0 = 1'b0;
    win_p0   = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef REGWR_ARB_RR_EN
      cand = scan_idx(rr_ptr, k);
`else
      cand = IDX_W'(k);
`endif
      if (!found_p0 && req_valid[cand]) begin
        found_p0 = 1'b1;
        win_p0   = cand;
      end
    end
  end

  // No grant while the bank is held or the block is in reset
  assign take_p0 = found_p0 && !hold && !reset;

  // One-hot grant and AND-OR selection of the winner's write
  always_comb begin
    grant_p0    = '0;
    sel_rd_p0   = '0;
    sel_data_p0 = '0;
    if (take_p0) grant_p0[win_p0] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_p0[i]) begin
        sel_rd_p0   = sel_rd_p0   | req_rd[i*RD_W +: RD_W];
        sel_data_p0 = sel_data_p0 | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = grant_p0;

`ifdef REGWR_ARB_RR_EN
  // Pointer moves just past the winner; wraps at the last requester
  always_comb begin
    rr_next = rr_ptr;
    if (take_p0) begin
      if (win_p0 == IDX_W'(NREQ-1)) rr_next = '0;
      else                          rr_next = win_p0 + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_ptr <= '0;
    else       rr_ptr <= rr_next;
  end
`endif

  // ---- stage p1: registered bank write ----
  // Capture the granted write; rd/data keep their value on idle cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= take_p0;
      if (take_p0) begin
        rd_p1   <= sel_rd_p0;
        data_p1 <= sel_data_p0;
      end
    end
  end

  assign WR   = vld_p1;
  assign rd   = rd_p1;
  assign data = data_p1;

  // Mark registers targeted by the output stage or by any pending request
  always_comb begin
    busy_mask = '0;
    if (vld_p1) busy_mask[rd_p1] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) busy_mask[req_rd[i*RD_W +: RD_W]] = 1'b1;
    end
  end

  localparam int UNUSED_NREG = NREG;

endmodule
